// File: rtl/rstmgr_pkg.sv
// Shared types and constants for the reset request controller.
package rstmgr_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StHold     = 2'd1,
        StWaitLow  = 2'd2,
        StWaitHigh = 2'd3
    } rst_req_state_e;

    localparam int unsigned CauseW    = 3;
    localparam int unsigned CauseSw   = 0;
    localparam int unsigned CauseWdog = 1;
    localparam int unsigned CauseDbg  = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_req_timer.sv
// Loadable down-counter that saturates at zero; shared by the hold and
// timeout phases since they never overlap.
module rst_req_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    localparam logic [Width-1:0] One = Width'(1);

    logic [Width-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - One;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rst_req_ctrl.sv
// Reset request controller: stretches and handshakes sw/wdog/dbg reset
// requests towards the reset manager and keeps a sticky cause record.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// StIdle     | no request outstanding, rst_req_o low
// StHold     | request asserted, minimum width running, level sources extend it
// StWaitLow  | request held, waiting for the manager to pull system reset low
// StWaitHigh | request dropped, waiting for system reset to be released
module rst_req_ctrl
    import rstmgr_pkg::*;
#(
    parameter int unsigned MinHoldCycles = 16,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sw_req_i,
    input  logic              wdog_req_i,
    input  logic              dbg_req_i,
    input  logic              sys_rst_ni_i,
    input  logic              cause_clr_i,
    output logic              rst_req_o,
    output logic              busy_o,
    output logic [CauseW-1:0] cause_o,
    output logic              err_o
);

    localparam int unsigned CntW = $clog2(max_u(MinHoldCycles, TimeoutCycles) + 1);
    // Loading N-1 gives exactly N cycles in the state before the zero flag ends it.
    localparam logic [CntW-1:0] HoldLoad    = CntW'(MinHoldCycles - 1);
    localparam logic [CntW-1:0] TimeoutLoad = CntW'(TimeoutCycles - 1);

    rst_req_state_e    state;
    logic              pending;
    logic              seen_low;
    logic              req_any;
    logic              hold_done;
    logic              timeout_hit;
    logic              timer_load;
    logic [CntW-1:0]   timer_val;
    logic              timer_en;
    logic              timer_zero;
    logic [CauseW-1:0] cause_set;

    assign req_any     = sw_req_i | wdog_req_i | dbg_req_i;
    assign hold_done   = (state == StHold) && timer_zero && !wdog_req_i && !dbg_req_i;
    assign timeout_hit = (state == StWaitLow) && sys_rst_ni_i && timer_zero;
    assign timer_en    = (state == StHold) || (state == StWaitLow);

    always_comb begin
        timer_load = 1'b0;
        timer_val  = HoldLoad;
        if ((state == StIdle) && (req_any || pending)) begin
            timer_load = 1'b1;
            timer_val  = HoldLoad;
        end else if (hold_done && !seen_low && sys_rst_ni_i) begin
            timer_load = 1'b1;
            timer_val  = TimeoutLoad;
        end
    end

    rst_req_timer #(
        .Width (CntW)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= StIdle;
            pending   <= 1'b0;
            seen_low  <= 1'b0;
            rst_req_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_any || pending) begin
                        state     <= StHold;
                        pending   <= 1'b0;
                        seen_low  <= 1'b0;
                        rst_req_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                StHold: begin
                    if (!sys_rst_ni_i) begin
                        seen_low <= 1'b1;
                    end
                    if (hold_done) begin
                        if (seen_low || !sys_rst_ni_i) begin
                            state     <= StWaitHigh;
                            rst_req_o <= 1'b0;
                        end else begin
                            state <= StWaitLow;
                        end
                    end
                end
                StWaitLow: begin
                    if (req_any) begin
                        pending <= 1'b1;
                    end
                    if (!sys_rst_ni_i) begin
                        state     <= StWaitHigh;
                        rst_req_o <= 1'b0;
                    end else if (timer_zero) begin
                        state     <= StIdle;
                        rst_req_o <= 1'b0;
                        busy_o    <= 1'b0;
                    end
                end
                StWaitHigh: begin
                    if (req_any) begin
                        pending <= 1'b1;
                    end
                    if (sys_rst_ni_i) begin
                        state  <= StIdle;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    rst_req_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cause_set            = '0;
        cause_set[CauseSw]   = sw_req_i;
        cause_set[CauseWdog] = wdog_req_i;
        cause_set[CauseDbg]  = dbg_req_i;
    end

    // Setting a bit takes priority over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cause_o <= '0;
            err_o   <= 1'b0;
        end else begin
            cause_o <= (cause_clr_i ? '0 : cause_o) | cause_set;
            err_o   <= (err_o & ~cause_clr_i) | timeout_hit;
        end
    end

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Bench for rst_req_ctrl: directed scenarios plus randomized single requests
// checked against an event-level timing model.
module tb_rst_req_ctrl;

    localparam int MIN_HOLD = 4;
    localparam int TIMEOUT  = 8;
    localparam int WIN      = 60;
    localparam int TRACE    = 8192;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       sw_req    = 1'b0;
    logic       wdog_req  = 1'b0;
    logic       dbg_req   = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       cause_clr = 1'b0;
    logic       rst_req;
    logic       busy;
    logic [2:0] cause;
    logic       err;

    int cyc       = 0;
    int tests_run = 0;
    int failed    = 0;

    bit req_tr  [TRACE];
    bit busy_tr [TRACE];
    bit err_tr  [TRACE];

    bit prev_req  = 1'b0;
    int mgr_start = -1000;
    bit mgr_en    = 1'b1;
    int mgr_d     = 2;
    int mgr_w     = 3;

    rst_req_ctrl #(
        .MinHoldCycles (MIN_HOLD),
        .TimeoutCycles (TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sw_req_i     (sw_req),
        .wdog_req_i   (wdog_req),
        .dbg_req_i    (dbg_req),
        .sys_rst_ni_i (sys_rst_n),
        .cause_clr_i  (cause_clr),
        .rst_req_o    (rst_req),
        .busy_o       (busy),
        .cause_o      (cause),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        req_tr[cyc % TRACE]  = rst_req;
        busy_tr[cyc % TRACE] = busy;
        err_tr[cyc % TRACE]  = err;
        if (rst_req && !prev_req) mgr_start = cyc + mgr_d;
        prev_req = rst_req;
    end

    // Reset manager stand-in: pulls system reset low mgr_d cycles after the request rises.
    always @(posedge clk) begin
        #1;
        sys_rst_n = !(mgr_en && (cyc >= mgr_start) && (cyc < mgr_start + mgr_w));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int src, input logic v);
        case (src)
            0:       sw_req   = v;
            1:       wdog_req = v;
            default: dbg_req  = v;
        endcase
    endtask

    task automatic clear_status();
        tick();
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
    endtask

    function automatic void measure(input int c0, output int rise, output int fall,
                                    output int bfall, output int erise);
        rise = -1; fall = -1; bfall = -1; erise = -1;
        for (int k = c0; k < c0 + WIN; k++) begin
            if (rise < 0 && req_tr[k % TRACE]) rise = k;
            else if (rise >= 0 && fall < 0 && !req_tr[k % TRACE]) fall = k;
            if (rise >= 0 && k > rise && bfall < 0 && !busy_tr[k % TRACE]) bfall = k;
            if (erise < 0 && err_tr[k % TRACE]) erise = k;
        end
    endfunction

    // Event-level expectation for one isolated request driven in cycle c0 for len cycles.
    function automatic void model(input int c0, input int len, input bit en, input int d,
                                  input int w, output int rise, output int fall,
                                  output int bfall, output int erise);
        int he;
        int m;
        rise  = c0 + 1;
        he    = (c0 + len > rise + MIN_HOLD - 1) ? c0 + len : rise + MIN_HOLD - 1;
        m     = en ? rise + d : 1 << 30;
        erise = -1;
        if (m <= he) begin
            fall  = he + 1;
            bfall = ((fall > m + w) ? fall : m + w) + 1;
        end else if (m <= he + TIMEOUT) begin
            fall  = m + 1;
            bfall = ((fall > m + w) ? fall : m + w) + 1;
        end else begin
            fall  = he + TIMEOUT + 1;
            bfall = fall;
            erise = fall;
        end
    endfunction

    task automatic test_reset();
        repeat (3) tick();
        tests_run++; if (rst_req !== 1'b0) begin failed++; $display("FAIL reset_req got %b want 0", rst_req); end
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (cause !== 3'b000) begin failed++; $display("FAIL reset_cause got %b want 000", cause); end
        tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL reset_err got %b want 0", err); end
        rst_n = 1'b1;
        repeat (5) tick();
        tests_run++; if (rst_req !== 1'b0) begin failed++; $display("FAIL post_reset_req got %b want 0", rst_req); end
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_sw_req();
        int c0, rise, fall, bfall, erise;
        tick();
        c0 = cyc;
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        while (cyc < c0 + WIN) tick();
        measure(c0, rise, fall, bfall, erise);
        tests_run++; if (rise !== c0 + 1) begin failed++; $display("FAIL sw_rise got %0d want %0d", rise - c0, 1); end
        tests_run++; if (busy_tr[(c0 + 1) % TRACE] !== 1'b1) begin failed++; $display("FAIL sw_busy_rise got 0 want 1"); end
        tests_run++; if (fall !== c0 + 5) begin failed++; $display("FAIL sw_fall got %0d want %0d", fall - c0, 5); end
        tests_run++; if (bfall !== c0 + 7) begin failed++; $display("FAIL sw_busy_fall got %0d want %0d", bfall - c0, 7); end
        tests_run++; if (cause !== 3'b001) begin failed++; $display("FAIL sw_cause got %b want 001", cause); end
        tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL sw_err got %b want 0", err); end
    endtask

    task automatic test_dbg_req();
        int c0, rise, fall, bfall, erise;
        clear_status();
        tick();
        c0 = cyc;
        dbg_req = 1'b1;
        repeat (20) tick();
        dbg_req = 1'b0;
        while (cyc < c0 + WIN) tick();
        measure(c0, rise, fall, bfall, erise);
        tests_run++; if (rise !== c0 + 1) begin failed++; $display("FAIL dbg_rise got %0d want %0d", rise - c0, 1); end
        tests_run++; if (fall !== c0 + 21) begin failed++; $display("FAIL dbg_fall got %0d want %0d", fall - c0, 21); end
        tests_run++; if (bfall !== c0 + 22) begin failed++; $display("FAIL dbg_busy_fall got %0d want %0d", bfall - c0, 22); end
        tests_run++; if (cause !== 3'b100) begin failed++; $display("FAIL dbg_cause got %b want 100", cause); end
        tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL dbg_err got %b want 0", err); end
    endtask

    task automatic test_timeout();
        int c0, rise, fall, bfall, erise;
        clear_status();
        mgr_en = 1'b0;
        tick();
        c0 = cyc;
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        while (cyc < c0 + 12) tick();
        tests_run++; if (cause !== 3'b001) begin failed++; $display("FAIL to_cause_pre got %b want 001", cause); end
        tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL to_err_early got %b want 0", err); end
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        tests_run++; if (err !== 1'b1) begin failed++; $display("FAIL to_err_set_wins got %b want 1", err); end
        tests_run++; if (cause !== 3'b000) begin failed++; $display("FAIL to_cause_cleared got %b want 000", cause); end
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL to_idle got busy %b want 0", busy); end
        while (cyc < c0 + WIN) tick();
        measure(c0, rise, fall, bfall, erise);
        tests_run++; if (rise !== c0 + 1) begin failed++; $display("FAIL to_rise got %0d want %0d", rise - c0, 1); end
        tests_run++; if (fall !== c0 + 13) begin failed++; $display("FAIL to_fall got %0d want %0d", fall - c0, 13); end
        tests_run++; if (erise !== c0 + 13) begin failed++; $display("FAIL to_err_rise got %0d want %0d", erise - c0, 13); end
        tests_run++; if (bfall !== c0 + 13) begin failed++; $display("FAIL to_busy_fall got %0d want %0d", bfall - c0, 13); end
        mgr_en = 1'b1;
    endtask

    task automatic test_pending();
        int c0, rise2;
        tick();
        c0 = cyc;
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        while (cyc < c0 + 5) tick();
        wdog_req = 1'b1;
        tick();
        wdog_req = 1'b0;
        while (cyc < c0 + WIN) tick();
        rise2 = -1;
        for (int k = c0 + 6; k < c0 + WIN; k++) begin
            if (rise2 < 0 && req_tr[k % TRACE]) rise2 = k;
        end
        tests_run++; if (req_tr[(c0 + 5) % TRACE] !== 1'b0) begin failed++; $display("FAIL pend_first_fall got 1 want 0"); end
        tests_run++; if (busy_tr[(c0 + 7) % TRACE] !== 1'b0) begin failed++; $display("FAIL pend_idle_gap got 1 want 0"); end
        tests_run++; if (rise2 !== c0 + 8) begin failed++; $display("FAIL pend_second_rise got %0d want %0d", rise2 - c0, 8); end
        tests_run++; if (req_tr[(c0 + 12) % TRACE] !== 1'b0 || req_tr[(c0 + 11) % TRACE] !== 1'b1)
            begin failed++; $display("FAIL pend_second_fall got %b%b want 10", req_tr[(c0 + 11) % TRACE], req_tr[(c0 + 12) % TRACE]); end
        tests_run++; if (busy_tr[(c0 + 14) % TRACE] !== 1'b0 || busy_tr[(c0 + 13) % TRACE] !== 1'b1)
            begin failed++; $display("FAIL pend_busy_fall got %b%b want 10", busy_tr[(c0 + 13) % TRACE], busy_tr[(c0 + 14) % TRACE]); end
        tests_run++; if (cause !== 3'b011) begin failed++; $display("FAIL pend_cause got %b want 011", cause); end
    endtask

    task automatic test_cause_clr();
        int c0;
        tick();
        c0 = cyc;
        cause_clr = 1'b1;
        sw_req    = 1'b1;
        tick();
        cause_clr = 1'b0;
        sw_req    = 1'b0;
        tests_run++; if (cause !== 3'b001) begin failed++; $display("FAIL clr_with_set got %b want 001", cause); end
        tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL clr_err got %b want 0", err); end
        while (cyc < c0 + WIN) tick();
        clear_status();
        tests_run++; if (cause !== 3'b000) begin failed++; $display("FAIL clr_alone got %b want 000", cause); end
    endtask

    task automatic test_rst_mid();
        int highs;
        tick();
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        tick();
        tests_run++; if (cause !== 3'b001 || rst_req !== 1'b1) begin failed++; $display("FAIL rmid_pre got cause %b req %b want 001 1", cause, rst_req); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (rst_req !== 1'b0) begin failed++; $display("FAIL rmid_req got %b want 0", rst_req); end
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL rmid_busy got %b want 0", busy); end
        tests_run++; if (cause !== 3'b000) begin failed++; $display("FAIL rmid_cause got %b want 000", cause); end
        tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL rmid_err got %b want 0", err); end
        repeat (2) tick();
        rst_n = 1'b1;
        highs = 0;
        repeat (20) begin
            tick();
            if (rst_req !== 1'b0 || busy !== 1'b0) highs++;
        end
        tests_run++; if (highs !== 0) begin failed++; $display("FAIL rmid_no_request got %0d active cycles want 0", highs); end
    endtask

    task automatic test_random();
        int c0, src, len, d, w;
        bit en;
        int rise, fall, bfall, erise;
        int e_rise, e_fall, e_bfall, e_erise;
        for (int it = 0; it < 20; it++) begin
            src = $urandom_range(0, 2);
            len = (src == 0) ? 1 : $urandom_range(1, 10);
            en  = ($urandom_range(0, 3) != 0);
            d   = $urandom_range(1, 14);
            w   = $urandom_range(1, 5);
            mgr_en = en;
            mgr_d  = d;
            mgr_w  = w;
            clear_status();
            tick();
            c0 = cyc;
            set_src(src, 1'b1);
            repeat (len) tick();
            set_src(src, 1'b0);
            while (cyc < c0 + WIN) tick();
            measure(c0, rise, fall, bfall, erise);
            model(c0, len, en, d, w, e_rise, e_fall, e_bfall, e_erise);
            tests_run++; if (rise !== e_rise) begin failed++; $display("FAIL rnd%0d_rise got %0d want %0d", it, rise - c0, e_rise - c0); end
            tests_run++; if (fall !== e_fall) begin failed++; $display("FAIL rnd%0d_fall got %0d want %0d (src %0d len %0d en %0d d %0d w %0d)", it, fall - c0, e_fall - c0, src, len, en, d, w); end
            tests_run++; if (bfall !== e_bfall) begin failed++; $display("FAIL rnd%0d_busy_fall got %0d want %0d", it, bfall - c0, e_bfall - c0); end
            tests_run++; if (erise !== e_erise) begin failed++; $display("FAIL rnd%0d_err got %0d want %0d", it, erise, e_erise); end
            tests_run++; if (cause !== (3'b001 << src)) begin failed++; $display("FAIL rnd%0d_cause got %b want %b", it, cause, 3'b001 << src); end
        end
        mgr_en = 1'b1;
        mgr_d  = 2;
        mgr_w  = 3;
    endtask

    initial begin
        test_reset();
        test_sw_req();
        test_dbg_req();
        test_timeout();
        test_pending();
        test_cause_clr();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
